// File: rtl/ising_pkg.sv
// Shared definitions for the Ising readout stage: Q16.16 phase thresholds,
// the phase/coupling word type and the evaluation FSM state encoding.
// No ports; imported by ising_phase_to_spin and ising_energy_eval.
package ising_pkg;

  // Phase/coupling word in the native Q16.16 format.
  localparam int DATA_WIDTH = 32;
  typedef logic signed [DATA_WIDTH-1:0] word_t;

  // Phase thresholds in Q16.16 radians. Held as longint so they can be
  // rescaled to other fractional widths without overflow.
  localparam longint PI_HALF       = 64'sd102944;
  localparam longint THREE_PI_HALF = 64'sd308831;
  localparam longint TWO_PI        = 64'sd411775;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    ACCUM  = 2'd2,
    FINISH = 2'd3
  } eval_state_t;

  // Re-express a non-negative Q16.16 constant with frac_bits fractional bits.
  function automatic longint q16_rescale(input longint value, input int frac_bits);
    if (frac_bits >= 16) begin
      return value <<< (frac_bits - 16);
    end
    return value >>> (16 - frac_bits);
  endfunction

endpackage

// File: rtl/ising_phase_to_spin.sv
// Binarises one oscillator phase into an Ising spin and flags out-of-range phases.
// Latency: purely combinational. Backpressure: none, output follows input.
// Ports: phase (signed, fractionalBits Q format) -> spin (1 = +1, 0 = -1),
//        out_of_range (phase < 0 or phase >= 2*pi).
module ising_phase_to_spin
  import ising_pkg::*;
#(
  parameter int dataWidth      = 32,
  parameter int fractionalBits = 16
) (
  input  logic signed [dataWidth-1:0] phase,
  output logic                        spin,
  output logic                        out_of_range
);

  localparam longint LO_EDGE  = q16_rescale(PI_HALF, fractionalBits);
  localparam longint HI_EDGE  = q16_rescale(THREE_PI_HALF, fractionalBits);
  localparam longint TOP_EDGE = q16_rescale(TWO_PI, fractionalBits);

  // Widen once so every comparison below is a plain signed 64-bit compare.
  logic signed [63:0] phase_ext;
  assign phase_ext = 64'(phase);

  // Phases near 0 (or near 2*pi) point "up"; the band [pi/2, 3*pi/2) points
  // "down". Out-of-range phases still go through the same rule.
  assign spin         = (phase_ext < LO_EDGE) || (phase_ext >= HI_EDGE);
  assign out_of_range = (phase_ext < 64'sd0) || (phase_ext >= TOP_EDGE);

endmodule

// File: rtl/ising_energy_eval.sv
// Readout stage: binarises N captured phases into spins, then accumulates
// E = -sum_{i<j} J_ij*s_i*s_j one pair per cycle.
// Latency: done pulses P+2 cycles after the start edge (P = N(N-1)/2).
// Backpressure: none; start is only sampled in IDLE, no queueing.
// Ports:
//   clk, n_rst          clock (rising edge), async active-low reset
//   start               begin an evaluation (sampled in IDLE only)
//   phases              N words, element i at [i*dataWidth +: dataWidth]
//   couplingMatrix      N*N words, J_ij at [(i*N+j)*dataWidth +: dataWidth];
//                       only i<j is read, must stay stable until done
//   spins               bit i = 1 means s_i = +1
//   energy              Hamiltonian, same Q format as the couplings
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle pulse when spins/energy are valid
//   range_err           sticky until next start: a captured phase was outside [0, 2*pi)
module ising_energy_eval
  import ising_pkg::*;
#(
  parameter int N              = 16,
  parameter int fractionalBits = 16,
  parameter int dataWidth      = 32,
  parameter int energyWidth    = dataWidth + 2*$clog2(N)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic [N*dataWidth-1:0]        phases,
  input  logic [N*N*dataWidth-1:0]      couplingMatrix,
  output logic [N-1:0]                  spins,
  output logic signed [energyWidth-1:0] energy,
  output logic                          busy,
  output logic                          done,
  output logic                          range_err
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N*N*dataWidth);

  eval_state_t state, state_next;

  logic signed [dataWidth-1:0]   phase_q [N];
  logic [N-1:0]                  spin_w;
  logic [N-1:0]                  oor_w;
  logic [IW-1:0]                 idx_i, idx_j;
  logic signed [energyWidth-1:0] acc, acc_next, j_ext;
  logic signed [dataWidth-1:0]   j_word;
  logic [CW-1:0]                 pair_base;
  logic                          last_pair;
  logic                          same_spin;

  // One binariser per captured phase.
  for (genvar g = 0; g < N; g++) begin : g_spin
    ising_phase_to_spin #(
      .dataWidth      (dataWidth),
      .fractionalBits (fractionalBits)
    ) u_spin (
      .phase        (phase_q[g]),
      .spin         (spin_w[g]),
      .out_of_range (oor_w[g])
    );
  end

  // Coupling for the current (i, j) pair, read straight from the input bus.
  assign pair_base = CW'((int'(idx_i) * N + int'(idx_j)) * dataWidth);
  assign j_word    = couplingMatrix[pair_base +: dataWidth];
  assign j_ext     = energyWidth'(j_word);

  // Aligned spins lower the energy by J_ij, opposed spins raise it.
  assign same_spin = (spins[idx_i] == spins[idx_j]);
  assign acc_next  = same_spin ? (acc - j_ext) : (acc + j_ext);
  assign last_pair = (idx_i == IW'(N-2)) && (idx_j == IW'(N-1));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SPIN;
      SPIN:    state_next = ACCUM;
      ACCUM:   if (last_pair) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < N; k++) begin
        phase_q[k] <= '0;
      end
      spins     <= '0;
      energy    <= '0;
      done      <= 1'b0;
      range_err <= 1'b0;
      acc       <= '0;
      idx_i     <= '0;
      idx_j     <= '0;
    end else begin
      // done is registered off FINISH, so it lands one cycle after FINISH
      // while the FSM is already back in IDLE.
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N; k++) begin
              phase_q[k] <= phases[k*dataWidth +: dataWidth];
            end
            range_err <= 1'b0;
          end
        end
        SPIN: begin
          spins     <= spin_w;
          range_err <= range_err | (|oor_w);
          acc       <= '0;
          idx_i     <= '0;
          idx_j     <= IW'(1);
        end
        ACCUM: begin
          acc <= acc_next;
          if (last_pair) begin
            energy <= acc_next;
          end else if (idx_j == IW'(N-1)) begin
            // Row exhausted: next row starts just right of the diagonal.
            idx_i <= idx_i + IW'(1);
            idx_j <= idx_i + IW'(2);
          end else begin
            idx_j <= idx_j + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
